// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and widths for the sequential 8x8 multiplier
package seq_mult_pkg;

    localparam int NIBBLE_W = 4;
    localparam int PP_W     = 2 * NIBBLE_W;
    localparam int PROD_W   = 4 * NIBBLE_W;

    localparam logic [1:0] LAST_STEP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pp_align.sv
// rtl/pp_align.sv - shifts a partial product to its weight for the current step
module pp_align #(
    parameter int NIBBLE_W = 4
) (
    input  logic [2*NIBBLE_W-1:0] pp,
    input  logic [1:0]            cnt,
    output logic [4*NIBBLE_W-1:0] term
);

    logic [4*NIBBLE_W-1:0] pp_ext;

    assign pp_ext = {{(2*NIBBLE_W){1'b0}}, pp};

    // Weight is the sum of the two selected nibble positions: 0, 1, 1, 2 nibbles.
    always_comb begin
        term = pp_ext;
        case (cnt)
            2'd0:    term = pp_ext;
            2'd3:    term = pp_ext << (2 * NIBBLE_W);
            default: term = pp_ext << NIBBLE_W;
        endcase
    end

endmodule

// File: rtl/seq_mult_accum.sv
// rtl/seq_mult_accum.sv - nibble-select sequencing and shift-accumulate of partial products
import seq_mult_pkg::*;

module seq_mult_accum #(
    parameter int NIBBLE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [2*NIBBLE_W-1:0] pp_in,
    output logic                  sel_a,
    output logic                  sel_b,
    output logic [4*NIBBLE_W-1:0] product,
    output logic                  busy,
    output logic                  done
);

    state_t                state;
    logic [1:0]            cnt;
    logic [4*NIBBLE_W-1:0] acc;
    logic [4*NIBBLE_W-1:0] term;

    pp_align #(.NIBBLE_W(NIBBLE_W)) u_pp_align (
        .pp   (pp_in),
        .cnt  (cnt),
        .term (term)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            acc     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        acc   <= '0;
                        cnt   <= 2'd0;
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc <= acc + term;
                    cnt <= cnt + 2'd1;
                    // Final step bypasses acc so product is ready on the same edge.
                    if (cnt == LAST_STEP) begin
                        product <= acc + term;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state == CALC);
    assign done  = (state == DONE);
    assign sel_a = busy & cnt[0];
    assign sel_b = busy & cnt[1];

endmodule

// File: tb/tb_seq_mult_accum.sv
// tb/tb_seq_mult_accum.sv - randomized self-checking bench with nibble mux and 4x4 multiplier model
import seq_mult_pkg::*;

module tb_seq_mult_accum;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [PP_W-1:0]   pp_in;
    logic              sel_a, sel_b;
    logic [PROD_W-1:0] product;
    logic              busy, done;

    logic [7:0] op_a = 8'h00;
    logic [7:0] op_b = 8'h00;
    logic [3:0] nib_a, nib_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign nib_a = sel_a ? op_a[7:4] : op_a[3:0];
    assign nib_b = sel_b ? op_b[7:4] : op_b[3:0];
    assign pp_in = {4'b0, nib_a} * {4'b0, nib_b};

    seq_mult_accum #(.NIBBLE_W(NIBBLE_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .pp_in   (pp_in),
        .sel_a   (sel_a),
        .sel_b   (sel_b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected (sel_a, sel_b) walk: A-nibble toggles fastest, B-nibble second.
    function automatic logic [7:0] exp_sel_seq();
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 4; i++) s[2*i +: 2] = {i[0], i[1]};
        return s;
    endfunction

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat,
                         output logic [15:0] prod, output logic [7:0] seq, output int nbusy);
        op_a = a;
        op_b = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        prod = 16'h0;
        seq = 8'h00;
        nbusy = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) nbusy++;
            if (i < 4) seq[2*i +: 2] = {sel_a, sel_b};
            if (done) begin
                lat = i;
                prod = product;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({product, busy, done, sel_a, sel_b} !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_hold: got prod=%h busy=%b done=%b sel=%b%b, want all zero",
                         product, busy, done, sel_a, sel_b);
            end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({product, busy, done, sel_a, sel_b} !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_idle: got prod=%h busy=%b done=%b sel=%b%b, want all zero",
                         product, busy, done, sel_a, sel_b);
            end
        end
    endtask

    task automatic test_single();
        int lat, nbusy;
        logic [15:0] prod, held;
        logic [7:0] seq;
        do_op(8'h12, 8'h34, lat, prod, seq, nbusy);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL single_latency: got %0d want 4", lat); end
        n_checks++;
        if (prod !== 16'(8'h12 * 8'h34)) begin
            n_fail++; $display("FAIL single_product: got %h want %h", prod, 16'(8'h12 * 8'h34));
        end
        n_checks++;
        if (seq !== exp_sel_seq()) begin
            n_fail++; $display("FAIL single_sel_seq: got %b want %b", seq, exp_sel_seq());
        end
        n_checks++;
        if (nbusy !== 4) begin n_fail++; $display("FAIL single_busy_cycles: got %0d want 4", nbusy); end
        held = prod;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (product !== held || done !== 1'b0) begin
                n_fail++;
                $display("FAIL single_hold: got prod=%h done=%b want prod=%h done=0", product, done, held);
            end
            tick();
        end
    endtask

    task automatic test_corners();
        logic [7:0] av [3] = '{8'hFF, 8'h00, 8'h01};
        logic [7:0] bv [3] = '{8'hFF, 8'hA7, 8'h01};
        int lat, nbusy;
        logic [15:0] prod;
        logic [7:0] seq;
        for (int k = 0; k < 3; k++) begin
            do_op(av[k], bv[k], lat, prod, seq, nbusy);
            n_checks++;
            if (lat !== 4 || prod !== 16'(av[k] * bv[k])) begin
                n_fail++;
                $display("FAIL corner_%0d: got lat=%0d prod=%h want lat=4 prod=%h",
                         k, lat, prod, 16'(av[k] * bv[k]));
            end
        end
    endtask

    task automatic test_back_to_back();
        int last = -1;
        int ndone = 0;
        op_a = 8'h0F;
        op_b = 8'h10;
        start = 1'b1;
        tick();
        for (int c = 0; c < 25; c++) begin
            if (done) begin
                ndone++;
                n_checks++;
                if ((last < 0 ? (c !== 4) : (c - last !== 5)) || product !== 16'(8'h0F * 8'h10)) begin
                    n_fail++;
                    $display("FAIL b2b_done: cycle %0d prev %0d prod=%h want spacing 5 prod=%h",
                             c, last, product, 16'(8'h0F * 8'h10));
                end
                last = c;
            end
            if (c == 24) start = 1'b0;
            tick();
        end
        n_checks++;
        if (ndone !== 5) begin n_fail++; $display("FAIL b2b_count: got %0d want 5", ndone); end
    endtask

    task automatic test_start_ignored();
        int lat = -1;
        op_a = 8'hC3;
        op_b = 8'h5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            start = (i == 1 || i == 2);
            if (done) begin lat = i; break; end
            tick();
        end
        n_checks++;
        if (lat !== 4 || product !== 16'(8'hC3 * 8'h5A)) begin
            n_fail++;
            $display("FAIL start_in_calc: got lat=%0d prod=%h want lat=4 prod=%h",
                     lat, product, 16'(8'hC3 * 8'h5A));
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, nbusy;
        logic [15:0] prod;
        logic [7:0] seq;
        op_a = 8'h12;
        op_b = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        @(posedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({product, busy, done, sel_a, sel_b} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got prod=%h busy=%b done=%b sel=%b%b, want all zero",
                     product, busy, done, sel_a, sel_b);
        end
        tick();
        reset_n = 1'b1;
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_mid_idle: got busy=%b done=%b want 00", busy, done);
        end
        do_op(8'h03, 8'h05, lat, prod, seq, nbusy);
        n_checks++;
        if (lat !== 4 || prod !== 16'h000F) begin
            n_fail++; $display("FAIL reset_mid_restart: got lat=%0d prod=%h want lat=4 prod=000f", lat, prod);
        end
    endtask

    task automatic test_random();
        int lat, nbusy;
        logic [15:0] prod;
        logic [7:0] seq, a, b;
        for (int k = 0; k < 16; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            do_op(a, b, lat, prod, seq, nbusy);
            n_checks++;
            if (lat !== 4 || prod !== 16'(a * b) || seq !== exp_sel_seq()) begin
                n_fail++;
                $display("FAIL random_%0d: a=%h b=%h got lat=%0d prod=%h seq=%b want lat=4 prod=%h seq=%b",
                         k, a, b, lat, prod, seq, 16'(a * b), exp_sel_seq());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_corners();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
